// File: rtl/digit_capture_pkg.sv
// digit_capture_pkg: shared state encoding, error codes and digit range for the capture controller
package digit_capture_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_LAUNCH, S_WAIT, S_DONE} state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [3:0] MAX_DIGIT   = 4'd9;
endpackage

// File: rtl/digit_capture_ctrl_frame_deserializer.sv
// frame_deserializer: writes LANES-wide beats into a flat image and flags the final beat of a frame
module frame_deserializer #(
  parameter int IMG_BITS = 784,
  parameter int LANES    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_restart,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [LANES-1:0]    i_data,
  output logic [IMG_BITS-1:0] o_image,
  output logic                o_last
);
  localparam int NBEATS = IMG_BITS / LANES;
  localparam int CW = $clog2(NBEATS + 1);
  logic [CW-1:0] r_cnt;
  logic [IMG_BITS-1:0] r_image;
  logic w_take;
  logic [CW-1:0] w_idx;
  // a restart beat always lands at beat 0, whatever the counter held
  assign w_take = i_valid && (i_restart || i_en);
  assign w_idx = i_restart ? '0 : r_cnt;
  assign o_last = w_take && (w_idx == CW'(NBEATS - 1));
  assign o_image = r_image;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_image <= '0;
    end else if (w_take) begin
      r_image[int'(w_idx)*LANES +: LANES] <= i_data;
      r_cnt <= w_idx + 1'b1;
    end else if (i_restart) begin
      r_cnt <= '0;
    end
  end
endmodule

// File: rtl/digit_capture_ctrl.sv
// digit_capture_ctrl: captures a multi-lane image frame, launches the classifier and
// returns its digit with timeout/range errors; re-arms from DONE without reset.
module digit_capture_ctrl
  import digit_capture_pkg::*;
#(
  parameter int PIXELS      = 784,
  parameter int PIX_W       = 1,
  parameter int LANES       = 1,
  parameter int TIMEOUT_CYC = 65535,
  localparam int IMG_BITS   = PIXELS * PIX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [LANES-1:0]    data_in,
  input  logic                data_valid,
  output logic                in_ready,
  output logic [IMG_BITS-1:0] image_out,
  output logic                cls_start,
  input  logic                cls_valid,
  input  logic [3:0]          cls_digit,
  output logic                busy,
  output logic [3:0]          digit_out,
  output logic                result_valid,
  output logic [1:0]          error,
  input  logic                result_ack
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  if ((IMG_BITS % LANES) != 0) begin : g_lane_check
    $error("LANES must divide PIXELS*PIX_W");
  end
  state_t r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic [3:0] r_digit;
  logic r_rv;
  logic [1:0] r_err;
  logic w_fs, w_last, w_expire;
  assign w_fs = frame_start && (r_state inside {S_IDLE, S_RECV, S_DONE});
  // r_tcnt counts cycles since cls_start, so expiry lands TIMEOUT_CYC cycles after launch
  assign w_expire = r_tcnt >= TW'(TIMEOUT_CYC - 1);
  frame_deserializer #(.IMG_BITS(IMG_BITS), .LANES(LANES)) u_deser (
    .clk(clk), .rst(rst), .i_restart(w_fs), .i_en(r_state == S_RECV),
    .i_valid(data_valid), .i_data(data_in), .o_image(image_out), .o_last(w_last)
  );
  always_comb begin
    w_next = r_state;
    w_next = w_last ? S_LAUNCH
      : w_fs ? S_RECV
      : (r_state == S_LAUNCH) ? S_WAIT
      : (r_state == S_WAIT && (cls_valid || w_expire)) ? S_DONE
      : (r_state == S_DONE && result_ack) ? S_IDLE
      : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tcnt <= '0;
      r_digit <= '0;
      r_rv <= 1'b0;
      r_err <= ERR_NONE;
    end else begin
      r_state <= w_next;
      r_tcnt <= (r_state == S_LAUNCH) ? TW'(1) : (r_state == S_WAIT) ? r_tcnt + 1'b1 : r_tcnt;
      if (r_state == S_WAIT && cls_valid) begin
        r_digit <= cls_digit;
        r_rv <= 1'b1;
        r_err <= (cls_digit > MAX_DIGIT) ? ERR_RANGE : ERR_NONE;
      end else if (r_state == S_WAIT && w_expire) begin
        r_digit <= 4'hF;
        r_rv <= 1'b1;
        r_err <= ERR_TIMEOUT;
      end else if (r_state == S_DONE && (frame_start || result_ack)) begin
        r_rv <= 1'b0;
        r_err <= ERR_NONE;
      end
    end
  end
  assign in_ready = r_state inside {S_IDLE, S_RECV, S_DONE};
  assign busy = r_state inside {S_RECV, S_LAUNCH, S_WAIT};
  assign cls_start = r_state == S_LAUNCH;
  assign digit_out = r_digit;
  assign result_valid = r_rv;
  assign error = r_err;
endmodule

// File: tb/tb_digit_capture_ctrl.sv
// tb_digit_capture_ctrl: directed/random checks of a default (1-lane) and an 8-lane, 16-cycle-timeout controller
module tb_digit_capture_ctrl;
  localparam int NB_B = 98;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic fs_a = 0, d_a = 0, dv_a = 0, cv_a = 0, ack_a = 0;
  logic [3:0] cd_a = 0;
  logic rdy_a, cs_a, busy_a, rv_a;
  logic [783:0] img_a;
  logic [3:0] dig_a;
  logic [1:0] err_a;

  logic fs_b = 0, dv_b = 0, cv_b = 0, ack_b = 0;
  logic [7:0] d_b = 0;
  logic [3:0] cd_b = 0;
  logic rdy_b, cs_b, busy_b, rv_b;
  logic [783:0] img_b;
  logic [3:0] dig_b;
  logic [1:0] err_b;

  int checks = 0, failures = 0;
  logic [783:0] exp_a, exp_b;
  logic [3:0] rnd_digit;
  logic ok;

  digit_capture_ctrl dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .data_in(d_a), .data_valid(dv_a),
    .in_ready(rdy_a), .image_out(img_a), .cls_start(cs_a), .cls_valid(cv_a),
    .cls_digit(cd_a), .busy(busy_a), .digit_out(dig_a), .result_valid(rv_a),
    .error(err_a), .result_ack(ack_a)
  );

  digit_capture_ctrl #(.LANES(8), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .data_in(d_b), .data_valid(dv_b),
    .in_ready(rdy_b), .image_out(img_b), .cls_start(cs_b), .cls_valid(cv_b),
    .cls_digit(cd_b), .busy(busy_b), .digit_out(dig_b), .result_valid(rv_b),
    .error(err_b), .result_ack(ack_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [783:0] obs, input logic [783:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one frame into dut_b; the first beat carries frame_start, stalls every 3rd cycle if asked
  task automatic send_b(input bit stall);
    int c = 0, k = 0;
    logic early = 0;
    while (k < NB_B) begin
      fs_b = (c == 0);
      dv_b = !(stall && (c % 3 == 2));
      d_b = 8'($urandom);
      if (dv_b) begin
        exp_b[k*8 +: 8] = d_b;
        k++;
      end
      tick();
      if (c == 0) chk("b_start_state", 784'({rv_b, err_b, busy_b}), 784'({1'b0, 2'd0, 1'b1}));
      if (k < NB_B) early |= cs_b;
      c++;
    end
    fs_b = 0;
    dv_b = 0;
    chk("b_no_early_launch", 784'(early), 784'(1'b0));
    chk("b_image", img_b, exp_b);
    chk("b_launch_latency", 784'(cs_b), 784'(1'b1));
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    chk("a_reset", 784'({img_a, rdy_a, cs_a, busy_a, rv_a, dig_a, err_a}), 784'({784'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0}));
    chk("b_reset", 784'({img_b}), 784'd0);
    chk("b_reset_outs", 784'({rdy_b, cs_b, busy_b, rv_b, dig_b, err_b}), 784'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0}));

    // dut_a: data_valid without frame_start in IDLE is ignored
    dv_a = 1; d_a = 1;
    tick();
    chk("a_idle_ignore", 784'({img_a[0], busy_a}), 784'(2'b00));

    // dut_a: 400 random beats, then restart with the alternating frame
    for (int k = 0; k < 400; k++) begin
      fs_a = (k == 0); dv_a = 1; d_a = 1'($urandom);
      tick();
    end
    chk("a_abort_no_launch", 784'({cs_a, busy_a}), 784'(2'b01));
    for (int k = 0; k < 784; k++) begin
      fs_a = (k == 0); dv_a = 1; d_a = (k % 2 == 0);
      exp_a[k] = (k % 2 == 0);
      tick();
      if (k == 782) chk("a_no_launch_before_last", 784'(cs_a), 784'(1'b0));
    end
    fs_a = 0; dv_a = 0;
    chk("a_image", img_a, exp_a);
    chk("a_launch_latency", 784'({cs_a, busy_a}), 784'(2'b11));
    tick();
    chk("a_launch_pulse_end", 784'({cs_a, busy_a}), 784'(2'b01));
    cv_a = 1; cd_a = 4'd7;
    tick();
    cv_a = 0;
    chk("a_result", 784'({rv_a, dig_a, err_a, busy_a}), 784'({1'b1, 4'd7, 2'd0, 1'b0}));
    ack_a = 1;
    tick();
    ack_a = 0;
    chk("a_ack", 784'({rv_a, err_a, rdy_a, busy_a}), 784'({1'b0, 2'd0, 1'b1, 1'b0}));

    // dut_b: stalled frame, classifier silent -> timeout 16 cycles after cls_start
    send_b(1);
    ok = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      ok &= (rv_b == 0) && (busy_b == 1) && (cs_b == 0);
    end
    chk("b_wait_silent", 784'(ok), 784'(1'b1));
    tick();
    chk("b_timeout", 784'({rv_b, dig_b, err_b, busy_b}), 784'({1'b1, 4'hF, 2'd1, 1'b0}));
    tick();
    chk("b_done_hold", 784'({rv_b, dig_b, err_b}), 784'({1'b1, 4'hF, 2'd1}));

    // dut_b: back-to-back frame straight from DONE; result arrives exactly at the expiry cycle
    send_b(0);
    for (int i = 1; i <= 15; i++) begin
      fs_b = (i == 5); dv_b = (i == 5); d_b = 8'($urandom);
      tick();
    end
    fs_b = 0; dv_b = 0;
    rnd_digit = 4'($urandom_range(9));
    cv_b = 1; cd_b = rnd_digit;
    tick();
    cv_b = 0;
    chk("b_valid_at_expiry", 784'({rv_b, dig_b, err_b, busy_b}), 784'({1'b1, rnd_digit, 2'd0, 1'b0}));
    chk("b_image_stable", img_b, exp_b);
    ack_b = 1;
    tick();
    ack_b = 0;
    chk("b_ack", 784'({rv_b, err_b, rdy_b, busy_b}), 784'({1'b0, 2'd0, 1'b1, 1'b0}));
    cv_b = 1; cd_b = 4'd3;
    tick();
    cv_b = 0;
    chk("b_idle_cls_ignored", 784'({rv_b, busy_b}), 784'(2'b00));

    // dut_b: out-of-range digit
    send_b(1);
    tick(); tick(); tick();
    cv_b = 1; cd_b = 4'd12;
    tick();
    cv_b = 0;
    chk("b_range_error", 784'({rv_b, dig_b, err_b, busy_b}), 784'({1'b1, 4'd12, 2'd2, 1'b0}));

    // dut_b: reset in the middle of a frame
    for (int k = 0; k < 20; k++) begin
      fs_b = (k == 0); dv_b = 1; d_b = 8'($urandom);
      tick();
    end
    fs_b = 0; dv_b = 0;
    chk("b_mid_recv_busy", 784'({busy_b, rv_b}), 784'(2'b10));
    rst = 1;
    tick();
    rst = 0;
    chk("b_rst_recv_img", img_b, 784'd0);
    chk("b_rst_recv_outs", 784'({rdy_b, cs_b, busy_b, rv_b, dig_b, err_b}), 784'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0}));

    // dut_b: reset while waiting for the classifier; a late result is ignored
    send_b(0);
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("b_rst_wait_outs", 784'({rdy_b, cs_b, busy_b, rv_b, dig_b, err_b}), 784'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0}));
    chk("b_rst_wait_img", img_b, 784'd0);
    cv_b = 1; cd_b = 4'd5;
    tick(); tick();
    cv_b = 0;
    chk("b_late_cls_ignored", 784'({rv_b, dig_b, busy_b, rdy_b}), 784'({1'b0, 4'd0, 1'b0, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/digit_capture_ctrl.md
Name: digit_capture_ctrl

Overview:
Parametrised successor to the single-lane handwriting front-end controller. It captures one image frame from a multi-lane serial stream with valid/stall support into a flat image register. It then launches the external classifier (mnist_model or a later generation) and returns the digit with timeout and range error reporting. Unlike the previous controller, it re-arms without reset, so frames can be processed back-to-back under one clock.

Parameters:
PIXELS, 784, pixels per frame
PIX_W, 1, bits per pixel (1 = binary, up to 8 = grayscale)
LANES, 1, data bits accepted per beat; must divide PIXELS*PIX_W (elaboration-time check)
TIMEOUT_CYC, 65535, max cycles to wait for cls_valid after cls_start
IMG_BITS, PIXELS*PIX_W, derived, not overridden

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
frame_start  in  1  pulse: begin a new frame (aborts any frame in progress)
data_in  in  LANES  serial data beat; lane 0 maps to the lowest image bit of the beat
data_valid  in  1  beat qualifier; low = stall, no count advance
in_ready  out  1  high in IDLE, RECV and DONE
image_out  out  IMG_BITS  captured frame to classifier
cls_start  out  1  one-cycle launch pulse to classifier
cls_valid  in  1  classifier result strobe
cls_digit  in  4  classifier result
busy  out  1  high in RECV, LAUNCH and WAIT
digit_out  out  4  registered result
result_valid  out  1  result/error available
error  out  2  0 ok, 1 timeout, 2 digit out of range (>9)
result_ack  in  1  consumer read result; returns to IDLE

Behaviour:
- Reset (synchronous, wins over all inputs, any state): state=IDLE; image_out=0; beat counter=0; timeout counter=0; cls_start=0; busy=0; digit_out=0; result_valid=0; error=0.
- States: IDLE, RECV, LAUNCH, WAIT, DONE.
- Beat k (0-based) writes image_out[k*LANES +: LANES]. Pixel p bit b is at index p*PIX_W+b. Beats per frame: NBEATS=IMG_BITS/LANES. Counter width is clog2(NBEATS+1).
- IDLE: frame_start -> RECV, counter=0. If data_valid is high in the same cycle, that beat is beat 0 and the counter becomes 1. data_valid without frame_start is ignored.
- RECV: each data_valid beat is written and the counter increments. When the last beat (k=NBEATS-1) is accepted at cycle N, the state is LAUNCH at N+1.
- frame_start in RECV restarts at beat 0; the concurrent data_valid beat counts as beat 0. Stale bits are not cleared; the new frame overwrites them.
- LAUNCH: cls_start=1 for exactly this cycle; image_out is stable from here until the next frame_start; go to WAIT.
- Last-beat-to-cls_start latency is 1 cycle.
- WAIT: the timeout counter increments each cycle. cls_valid is sampled only in WAIT and ignored elsewhere.
- On cls_valid: digit_out=cls_digit, result_valid=1, error=(cls_digit>9)?2:0 at the next edge; go to DONE.
- If the counter reaches TIMEOUT_CYC with no cls_valid: digit_out=4'hF, error=1, result_valid=1 -> DONE. cls_valid in the same cycle as expiry wins (normal result).
- frame_start in LAUNCH/WAIT is ignored (classifier in flight).
- DONE: result_valid, digit_out and error are held.
- DONE + result_ack -> IDLE; result_valid=0 and error=0 next cycle.
- DONE + frame_start -> RECV directly, clears result_valid/error; a same-cycle data_valid beat is beat 0. frame_start has priority over result_ack.
- busy and result_valid are never high together.

Decomposition:
- Package digit_capture_pkg: state encoding, error code constants (ERR_NONE, ERR_TIMEOUT, ERR_RANGE), MAX_DIGIT=9.
- One sub-module, frame_deserializer: beat counter, lane write, last-beat flag, restart input. The FSM, timeout and result registers stay in the top.

Test Plan:
- Default params, 784 beats of alternating 1/0 after frame_start -> image_out=...0101, cls_start high exactly 1 cycle after beat 783; cls_valid with digit 7 -> digit_out=7, result_valid=1, error=0, busy=0.
- LANES=8, 98 beats with data_valid deasserted every 3rd cycle -> beat count unaffected by stalls, exact image match, cls_start 1 cycle after beat 97.
- frame_start at beat 400 with new data -> capture restarts; cls_start only after 784 new beats; image equals second frame.
- TIMEOUT_CYC=16, classifier silent -> result_valid=1, error=1, digit_out=4'hF at 16 cycles after cls_start. Repeat with cls_valid at the expiry cycle -> error=0, classifier digit.
- cls_digit=12 -> error=2, digit_out=12. Then result_ack -> IDLE, result_valid=0. Then frame_start in DONE with a second frame -> back-to-back result without reset.
- rst asserted mid-RECV and mid-WAIT -> all outputs zero next edge; a late cls_valid after reset is ignored.
